// File: rtl/vec_issue_seq.sv
// ----------------------------------------------------------------------------
// vec_issue_seq
//
// Purpose
//    Sequencer that accepts one vector instruction at a time from the scalar
//    issue stage and replays it as a stream of element operations into a single
//    shared lane ALU.  While an instruction is in flight the scalar pipeline
//    is asked to stall.  Non-vector opcodes offered while idle are flagged as
//    illegal and dropped.
//
// Parameters
//    VL_MAX : maximum elements per vector instruction (2..15); longer requested
//             lengths are clamped to this value.
//    CNT_W  : width of the lane-backpressure cycle counter.
//
// Ports
//    clk_i          in   clock, all state on the rising edge
//    rst_i          in   asynchronous active-high reset
//    issue_valid_i  in   an instruction is offered
//    issue_ready_o  out  sequencer is idle and accepts an instruction
//    opcode_i       in   [6:0] major opcode (7'b1010111 = vector)
//    funct6_i       in   [5:0] vector operation select
//    vd_i/vs1_i/vs2_i in [4:0] destination / source register indices
//    vl_i           in   [3:0] requested vector length
//    lane_valid_o   out  element operation presented to the lane
//    lane_ready_i   in   lane accepts the presented element
//    lane_idx_o     out  [3:0] element index being presented
//    lane_op_o      out  [5:0] latched funct6
//    lane_vd_o/lane_vs1_o/lane_vs2_o out [4:0] latched register indices
//    stall_o        out  scalar-pipeline stall while busy
//    done_o         out  one-cycle pulse on instruction completion
//    illegal_o      out  one-cycle pulse after a non-vector opcode is offered
//    bp_cnt_o       out  [CNT_W-1:0] lane backpressure cycle count
//
// Configuration
//    VSEQ_BPCNT_EN : when defined, bp_cnt_o counts (saturating) every cycle an
//                    element is presented but not accepted.  When undefined
//                    bp_cnt_o is tied to zero and no counter is built.
// ----------------------------------------------------------------------------
module vec_issue_seq #(
   parameter int VL_MAX = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_valid_i,
   output logic             issue_ready_o,
   input  logic [6:0]       opcode_i,
   input  logic [5:0]       funct6_i,
   input  logic [4:0]       vd_i,
   input  logic [4:0]       vs1_i,
   input  logic [4:0]       vs2_i,
   input  logic [3:0]       vl_i,
   output logic             lane_valid_o,
   input  logic             lane_ready_i,
   output logic [3:0]       lane_idx_o,
   output logic [5:0]       lane_op_o,
   output logic [4:0]       lane_vd_o,
   output logic [4:0]       lane_vs1_o,
   output logic [4:0]       lane_vs2_o,
   output logic             stall_o,
   output logic             done_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] bp_cnt_o
);

   localparam logic [6:0] OP_VECTOR = 7'b1010111;
   localparam logic [3:0] VL_MAX_C  = 4'(VL_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] vl_q, vl_d;
   logic [5:0] op_q, op_d;
   logic [4:0] vd_q, vd_d;
   logic [4:0] vs1_q, vs1_d;
   logic [4:0] vs2_q, vs2_d;
   logic       lane_valid_q, lane_valid_d;
   logic       done_q, done_d;
   logic       illegal_q, illegal_d;
   logic       stall_q, stall_d;
   logic       ready_q, ready_d;

   logic [3:0] vl_eff;
   logic       lane_hs;
   logic       last_elem;

   // Requested length clamped to the hardware maximum.
   assign vl_eff    = (vl_i > VL_MAX_C) ? VL_MAX_C : vl_i;
   assign lane_hs   = lane_valid_q & lane_ready_i;
   // vl_q is never zero while in S_ISSUE, so the subtraction cannot wrap there.
   assign last_elem = (idx_q == 4'(vl_q - 4'd1));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vl_d      = vl_q;
      op_d      = op_q;
      vd_d      = vd_q;
      vs1_d     = vs1_q;
      vs2_d     = vs2_q;
      illegal_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (issue_valid_i) begin
               if (opcode_i == OP_VECTOR) begin
                  op_d   = funct6_i;
                  vd_d   = vd_i;
                  vs1_d  = vs1_i;
                  vs2_d  = vs2_i;
                  vl_d   = vl_eff;
                  idx_d  = 4'd0;
                  // A zero-length instruction completes without touching the lane.
                  state_d = (vl_eff != 4'd0) ? S_ISSUE : S_DONE;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end

         S_ISSUE: begin
            // Without a handshake every lane field keeps its value, which gives
            // the lane stable inputs while it backpressures.
            if (lane_hs) begin
               idx_d = idx_q + 4'd1;
               if (last_elem) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are a function of the next state so that they come straight
      // out of flops and line up with the state they describe.
      lane_valid_d = (state_d == S_ISSUE);
      done_d       = (state_d == S_DONE);
      stall_d      = (state_d != S_IDLE);
      ready_d      = (state_d == S_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= 4'd0;
         vl_q         <= 4'd0;
         op_q         <= 6'd0;
         vd_q         <= 5'd0;
         vs1_q        <= 5'd0;
         vs2_q        <= 5'd0;
         lane_valid_q <= 1'b0;
         done_q       <= 1'b0;
         illegal_q    <= 1'b0;
         stall_q      <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         vl_q         <= vl_d;
         op_q         <= op_d;
         vd_q         <= vd_d;
         vs1_q        <= vs1_d;
         vs2_q        <= vs2_d;
         lane_valid_q <= lane_valid_d;
         done_q       <= done_d;
         illegal_q    <= illegal_d;
         stall_q      <= stall_d;
         ready_q      <= ready_d;
      end
   end

   assign issue_ready_o = ready_q;
   assign lane_valid_o  = lane_valid_q;
   assign lane_idx_o    = idx_q;
   assign lane_op_o     = op_q;
   assign lane_vd_o     = vd_q;
   assign lane_vs1_o    = vs1_q;
   assign lane_vs2_o    = vs2_q;
   assign stall_o       = stall_q;
   assign done_o        = done_q;
   assign illegal_o     = illegal_q;

   // ------------------------------------------------------------------------
   // Lane backpressure counter
   // ------------------------------------------------------------------------
`ifdef VSEQ_BPCNT_EN
   logic [CNT_W-1:0] bp_cnt_q, bp_cnt_d;

   always_comb begin
      bp_cnt_d = bp_cnt_q;
      // Saturate rather than wrap so a long-running count never reads small.
      if (lane_valid_q && !lane_ready_i && (bp_cnt_q != {CNT_W{1'b1}})) begin
         bp_cnt_d = bp_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bp_cnt_q <= '0;
      end else begin
         bp_cnt_q <= bp_cnt_d;
      end
   end

   assign bp_cnt_o = bp_cnt_q;
`else
   assign bp_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vec_issue_seq.sv
// ----------------------------------------------------------------------------
// tb_vec_issue_seq
//
// Directed bench for vec_issue_seq with default parameters (VL_MAX=8,
// CNT_W=16).  Inputs change 1 time unit after each rising edge and outputs
// are checked at that same point, so every check sees settled flop values.
// Expected backpressure counts follow VSEQ_BPCNT_EN.
// ----------------------------------------------------------------------------
module tb_vec_issue_seq;

   localparam logic [6:0] OP_V  = 7'b1010111;
   localparam logic [6:0] OP_RV = 7'b0110011;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic [6:0]  opcode_i;
   logic [5:0]  funct6_i;
   logic [4:0]  vd_i, vs1_i, vs2_i;
   logic [3:0]  vl_i;
   logic        lane_valid_o;
   logic        lane_ready_i;
   logic [3:0]  lane_idx_o;
   logic [5:0]  lane_op_o;
   logic [4:0]  lane_vd_o, lane_vs1_o, lane_vs2_o;
   logic        stall_o;
   logic        done_o;
   logic        illegal_o;
   logic [15:0] bp_cnt_o;

   int n_checks = 0;
   int n_fails  = 0;

   vec_issue_seq dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .issue_valid_i (issue_valid_i),
      .issue_ready_o (issue_ready_o),
      .opcode_i      (opcode_i),
      .funct6_i      (funct6_i),
      .vd_i          (vd_i),
      .vs1_i         (vs1_i),
      .vs2_i         (vs2_i),
      .vl_i          (vl_i),
      .lane_valid_o  (lane_valid_o),
      .lane_ready_i  (lane_ready_i),
      .lane_idx_o    (lane_idx_o),
      .lane_op_o     (lane_op_o),
      .lane_vd_o     (lane_vd_o),
      .lane_vs1_o    (lane_vs1_o),
      .lane_vs2_o    (lane_vs2_o),
      .stall_o       (stall_o),
      .done_o        (done_o),
      .illegal_o     (illegal_o),
      .bp_cnt_o      (bp_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic offer(input logic [6:0] opc, input logic [5:0] f6, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [3:0] vl);
      issue_valid_i = 1'b1;
      opcode_i      = opc;
      funct6_i      = f6;
      vd_i          = d;
      vs1_i         = s1;
      vs2_i         = s2;
      vl_i          = vl;
   endtask

   // Checks one presented element including the latched fields.
   task automatic check_elem(input string tag, input int idx, input logic [5:0] f6,
                             input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
      check({tag, ".valid"}, 32'(lane_valid_o), 32'd1);
      check({tag, ".idx"},   32'(lane_idx_o),   32'(idx));
      check({tag, ".op"},    32'(lane_op_o),    32'(f6));
      check({tag, ".vd"},    32'(lane_vd_o),    32'(d));
      check({tag, ".vs1"},   32'(lane_vs1_o),   32'(s1));
      check({tag, ".vs2"},   32'(lane_vs2_o),   32'(s2));
      check({tag, ".stall"}, 32'(stall_o),      32'd1);
      check({tag, ".done"},  32'(done_o),       32'd0);
      check({tag, ".rdy"},   32'(issue_ready_o), 32'd0);
   endtask

   task automatic check_done_cycle(input string tag);
      check({tag, ".done"},  32'(done_o),        32'd1);
      check({tag, ".valid"}, 32'(lane_valid_o),  32'd0);
      check({tag, ".stall"}, 32'(stall_o),       32'd1);
      check({tag, ".rdy"},   32'(issue_ready_o), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".done"},  32'(done_o),        32'd0);
      check({tag, ".valid"}, 32'(lane_valid_o),  32'd0);
      check({tag, ".stall"}, 32'(stall_o),       32'd0);
      check({tag, ".rdy"},   32'(issue_ready_o), 32'd1);
   endtask

   initial begin
      logic [15:0] bp_exp;

      rst_i         = 1'b1;
      issue_valid_i = 1'b0;
      opcode_i      = 7'd0;
      funct6_i      = 6'd0;
      vd_i          = 5'd0;
      vs1_i         = 5'd0;
      vs2_i         = 5'd0;
      vl_i          = 4'd0;
      lane_ready_i  = 1'b1;

      // ---------------- reset state ----------------
      #2;
      check("rst.rdy",     32'(issue_ready_o), 32'd1);
      check("rst.valid",   32'(lane_valid_o),  32'd0);
      check("rst.idx",     32'(lane_idx_o),    32'd0);
      check("rst.stall",   32'(stall_o),       32'd0);
      check("rst.done",    32'(done_o),        32'd0);
      check("rst.illegal", 32'(illegal_o),     32'd0);
      check("rst.op",      32'(lane_op_o),     32'd0);
      check("rst.bp",      32'(bp_cnt_o),      32'd0);
      tick();
      rst_i = 1'b0;
      tick();

      // ---------------- vl=4, lane always ready ----------------
      offer(OP_V, 6'h15, 5'd3, 5'd5, 5'd7, 4'd4);
      check("t1.rdy0", 32'(issue_ready_o), 32'd1);
      tick();
      // An offer during the instruction must be ignored and never flagged.
      offer(OP_RV, 6'h3f, 5'd31, 5'd31, 5'd31, 4'd9);
      for (int i = 0; i < 4; i++) begin
         check_elem("t1", i, 6'h15, 5'd3, 5'd5, 5'd7);
         check("t1.illegal", 32'(illegal_o), 32'd0);
         tick();
      end
      issue_valid_i = 1'b0;
      check_done_cycle("t1.end");
      check("t1.illegal_d", 32'(illegal_o), 32'd0);
      tick();
      check_idle("t1.idle");
      check("t1.bp", 32'(bp_cnt_o), 32'd0);

      // ---------------- vl=3, lane stalls two cycles at idx 1 ----------------
      offer(OP_V, 6'h2a, 5'd1, 5'd2, 5'd4, 4'd3);
      tick();
      issue_valid_i = 1'b0;
      check_elem("t2.e0", 0, 6'h2a, 5'd1, 5'd2, 5'd4);
      tick();
      lane_ready_i = 1'b0;
      check_elem("t2.e1a", 1, 6'h2a, 5'd1, 5'd2, 5'd4);
      tick();
      check_elem("t2.e1b", 1, 6'h2a, 5'd1, 5'd2, 5'd4);
      tick();
      lane_ready_i = 1'b1;
      check_elem("t2.e1c", 1, 6'h2a, 5'd1, 5'd2, 5'd4);
      tick();
      check_elem("t2.e2", 2, 6'h2a, 5'd1, 5'd2, 5'd4);
      tick();
      check_done_cycle("t2.end");
`ifdef VSEQ_BPCNT_EN
      bp_exp = 16'd2;
`else
      bp_exp = 16'd0;
`endif
      check("t2.bp", 32'(bp_cnt_o), 32'(bp_exp));
      tick();
      check_idle("t2.idle");

      // ---------------- vl=12 clamped to VL_MAX=8 ----------------
      offer(OP_V, 6'h01, 5'd10, 5'd11, 5'd12, 4'd12);
      tick();
      issue_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_elem("t3", i, 6'h01, 5'd10, 5'd11, 5'd12);
         tick();
      end
      check_done_cycle("t3.end");
      tick();
      check_idle("t3.idle");

      // ---------------- vl=0 ----------------
      offer(OP_V, 6'h07, 5'd8, 5'd9, 5'd6, 4'd0);
      tick();
      issue_valid_i = 1'b0;
      check_done_cycle("t4.end");
      check("t4.op", 32'(lane_op_o), 32'h07);
      tick();
      check_idle("t4.idle");

      // ---------------- illegal opcode in IDLE ----------------
      offer(OP_RV, 6'h30, 5'd20, 5'd21, 5'd22, 4'd5);
      tick();
      issue_valid_i = 1'b0;
      check("t5.illegal", 32'(illegal_o),     32'd1);
      check("t5.rdy",     32'(issue_ready_o), 32'd1);
      check("t5.valid",   32'(lane_valid_o),  32'd0);
      check("t5.stall",   32'(stall_o),       32'd0);
      check("t5.op",      32'(lane_op_o),     32'h07);
      check("t5.vd",      32'(lane_vd_o),     32'd8);
      tick();
      check("t5.illegal_end", 32'(illegal_o), 32'd0);
      check_idle("t5.idle");

      // ---------------- async reset at idx 2 of vl=6 ----------------
      offer(OP_V, 6'h11, 5'd4, 5'd5, 5'd6, 4'd6);
      tick();
      issue_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_elem("t6", i, 6'h11, 5'd4, 5'd5, 5'd6);
         if (i < 2) tick();
      end
      rst_i = 1'b1;
      #1;
      check("t6.rst.valid", 32'(lane_valid_o),  32'd0);
      check("t6.rst.idx",   32'(lane_idx_o),    32'd0);
      check("t6.rst.stall", 32'(stall_o),       32'd0);
      check("t6.rst.rdy",   32'(issue_ready_o), 32'd1);
      check("t6.rst.op",    32'(lane_op_o),     32'd0);
      check("t6.rst.vs2",   32'(lane_vs2_o),    32'd0);
      check("t6.rst.bp",    32'(bp_cnt_o),      32'd0);
      tick();
      check("t6.rst.done", 32'(done_o), 32'd0);
      rst_i = 1'b0;
      tick();
      check_idle("t6.post");

      offer(OP_V, 6'h22, 5'd1, 5'd3, 5'd5, 4'd2);
      tick();
      issue_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_elem("t6.new", i, 6'h22, 5'd1, 5'd3, 5'd5);
         tick();
      end
      check_done_cycle("t6.new.end");
      tick();
      check_idle("t6.new.idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
